// File: rtl/run_controller_pkg.sv
// Shared types and constants for the run sequencer.
package run_controller_pkg;

  // Sequencer states, also exported on the debug port.
  typedef enum logic [2:0] {
    RC_IDLE,
    RC_LOAD,
    RC_RUN,
    RC_DONE,
    RC_FAULT
  } rc_state_t;

  // Final PC of each program, indexed by prog_sel.
  localparam logic [9:0] DONE_ADDR [4] = '{10'd431, 10'd596, 10'd3, 10'd35};

  // Look up the done address for a latched program select.
  function automatic logic [9:0] done_addr(input logic [1:0] sel);
    return DONE_ADDR[sel];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear has priority over enable.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins, otherwise increment unless saturated.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/run_controller.sv
// Run sequencer: turns the req level into a PC start window and a core run
// enable, then ends the run on the program's done PC or on budget overrun.
//
// Handshake: req is a level held for the whole run. ack rises when the run
// ends (done or fault) and stays high until req is seen low; ack/fault then
// drop on the following cycle. Dropping req before ack aborts the run with
// no ack. A new run starts only on a fresh rising edge of req.
module run_controller
  import run_controller_pkg::*;
#(
  parameter int PC_BITS      = 10,
  parameter int CNT_BITS     = 16,
  parameter int START_CYCLES = 2,
  parameter int MAX_CYCLES   = 60000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req,
  input  logic [1:0]          prog_sel,
  input  logic [PC_BITS-1:0]  pc,
  output logic                start,
  output logic                run_en,
  output logic                busy,
  output logic                ack,
  output logic                fault,
  output logic [CNT_BITS-1:0] cycle_count,
  output rc_state_t           state_dbg
);

  localparam int LD_BITS = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [LD_BITS-1:0] LD_LAST = LD_BITS'(START_CYCLES - 1);
  // The counter increments on the same edge the budget is checked, so the
  // check fires one count early and the run ends showing MAX_CYCLES-1.
  localparam logic [CNT_BITS-1:0] BUDGET_LAST = CNT_BITS'(MAX_CYCLES - 2);

  rc_state_t          state_q, state_d;
  logic               req_q;
  logic [1:0]         sel_q, sel_d;
  logic [LD_BITS-1:0] ld_cnt_q, ld_cnt_d;

  logic               rise;
  logic               done_hit;
  logic               budget_hit;
  logic               cnt_clear;
  logic               cnt_en;
  logic [PC_BITS-1:0] done_pc;

  assign rise       = req & ~req_q;
  assign done_pc    = PC_BITS'(done_addr(sel_q));
  assign done_hit   = (pc == done_pc);
  assign budget_hit = (cycle_count == BUDGET_LAST);

  // State, request history, program select and load counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= RC_IDLE;
      req_q    <= 1'b0;
      sel_q    <= 2'd0;
      ld_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req;
      sel_q    <= sel_d;
      ld_cnt_q <= ld_cnt_d;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ld_cnt_d  = ld_cnt_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    start     = 1'b0;
    run_en    = 1'b0;
    busy      = 1'b0;
    ack       = 1'b0;
    fault     = 1'b0;
    case (state_q)
      RC_IDLE: begin
        if (rise) begin
          state_d   = RC_LOAD;
          sel_d     = prog_sel;
          ld_cnt_d  = '0;
          cnt_clear = 1'b1;
        end
      end
      RC_LOAD: begin
        start = 1'b1;
        busy  = 1'b1;
        if (!req) begin
          state_d = RC_IDLE;
        end else if (ld_cnt_q == LD_LAST) begin
          state_d = RC_RUN;
        end else begin
          ld_cnt_d = ld_cnt_q + 1'b1;
        end
      end
      RC_RUN: begin
        run_en = 1'b1;
        busy   = 1'b1;
        cnt_en = 1'b1;
        // Abort first, then done beats budget when both land together.
        if (!req) begin
          state_d = RC_IDLE;
        end else if (done_hit) begin
          state_d = RC_DONE;
        end else if (budget_hit) begin
          state_d = RC_FAULT;
        end
      end
      RC_DONE: begin
        ack = 1'b1;
        if (!req) state_d = RC_IDLE;
      end
      RC_FAULT: begin
        ack   = 1'b1;
        fault = 1'b1;
        if (!req) state_d = RC_IDLE;
      end
      default: begin
        state_d = RC_IDLE;
      end
    endcase
  end

  sat_counter #(
    .W(CNT_BITS)
  ) u_cycle_cnt (
    .clk_i   (clock),
    .rst_i   (reset),
    .clear_i (cnt_clear),
    .en_i    (cnt_en),
    .count_o (cycle_count)
  );

  assign state_dbg = state_q;

endmodule
